// File: rtl/lcd_bus_arbiter.sv
// Arbitrates the shared LCD data bus between the setup engine and the character
// generator, and generates the HD44780 RS/E write strobe plus post-write settle time.
module lcd_bus_arbiter #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 12,
  parameter int HOLD_CYC     = 2,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       setupReq,
  input  logic       setupRs,
  input  logic       charReq,
  input  logic       charRs,
  input  logic       setupDone,
  input  logic [7:0] dIn,
  output logic       setupAck,
  output logic       charAck,
  output logic [1:0] dOutSel,
  output logic       lcdRs,
  output logic       lcdRw,
  output logic       lcdE,
  output logic       busy,
  output logic [2:0] dbgState
);

  // Handshake: a requester raises req and holds it (with its RS/data) until it sees
  // its one-cycle ack, then drops req on the following edge.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_ACK   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_WAIT_CYC - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic             rs_q;
  logic             e_q;
  logic             setup_ack_q;
  logic             char_ack_q;
  logic             busy_q;
  logic             is_clr_q;

  logic             cnt_done;
  logic             is_clr_d;
  logic [CNT_W-1:0] wait_ld_d;

  // Clear/home (0x01..0x03 on the command register) needs the long settle time.
  assign cnt_done  = (cnt_q == '0);
  assign is_clr_d  = !rs_q && (dIn[7:2] == 6'd0) && (dIn[1:0] != 2'd0);
  assign wait_ld_d = is_clr_q ? LD_CLR : LD_WAIT;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= 2'd0;
      rs_q        <= 1'b0;
      e_q         <= 1'b0;
      setup_ack_q <= 1'b0;
      char_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      is_clr_q    <= 1'b0;
    end else begin
      setup_ack_q <= 1'b0;
      char_ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (setupReq) begin
            sel_q   <= 2'd0;
            rs_q    <= setupRs;
            cnt_q   <= LD_SETUP;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end else if (charReq && setupDone) begin
            sel_q   <= 2'd1;
            rs_q    <= charRs;
            cnt_q   <= LD_SETUP;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            is_clr_q <= is_clr_d;
            e_q      <= 1'b1;
            cnt_q    <= LD_PULSE;
            state_q  <= ST_PULSE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_done) begin
            e_q     <= 1'b0;
            cnt_q   <= LD_HOLD;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            cnt_q   <= wait_ld_d;
            state_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_done) begin
            setup_ack_q <= (sel_q == 2'd0);
            char_ack_q  <= (sel_q == 2'd1);
            state_q     <= ST_ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ACK: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          e_q     <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign setupAck = setup_ack_q;
  assign charAck  = char_ack_q;
  assign dOutSel  = sel_q;
  assign lcdRs    = rs_q;
  assign lcdRw    = 1'b0;
  assign lcdE     = e_q;
  assign busy     = busy_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed test-plan scenarios followed by random
// request traffic, all checked against a transaction-timeline reference model.
module tb_lcd_bus_arbiter;

  localparam int S   = 2;
  localparam int P   = 3;
  localparam int H   = 2;
  localparam int W   = 4;
  localparam int CLR = 10;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rstN, setupReq, setupRs, charReq, charRs, setupDone;
  logic [7:0] setup_data, char_data, dIn;
  logic       setupAck, charAck, lcdRs, lcdRw, lcdE, busy;
  logic [1:0] dOutSel;
  logic [2:0] dbgState;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External data mux feeding the bus value back to the arbiter.
  assign dIn = (dOutSel == 2'd1) ? char_data : setup_data;

  lcd_bus_arbiter #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .WAIT_CYC(W), .CLR_WAIT_CYC(CLR), .CNT_W(17)
  ) dut (
    .clk(clk), .rstN(rstN), .setupReq(setupReq), .setupRs(setupRs),
    .charReq(charReq), .charRs(charRs), .setupDone(setupDone), .dIn(dIn),
    .setupAck(setupAck), .charAck(charAck), .dOutSel(dOutSel), .lcdRs(lcdRs),
    .lcdRw(lcdRw), .lcdE(lcdE), .busy(busy), .dbgState(dbgState)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // A write granted in IDLE cycle g occupies cycles g+1..end, E is high in
  // g+S+1..g+S+P, and the ack lands on cycle end = g+1+S+P+H+settle.
  bit          m_active = 1'b0;
  bit          m_who    = 1'b0;
  int          m_g      = 0;
  int          m_end    = 0;
  bit          m_sel    = 1'b0;
  bit          m_rs     = 1'b0;
  logic [31:0] exp_q[$];

  bit seen_sack = 1'b0, seen_cack = 1'b0;
  int last_sack = -1, last_cack = -1;
  int e_rise = -1, e_last = -1;
  bit prev_e = 1'b0, any_busy = 1'b0;

  task automatic model_grant(input bit who, input bit rs, input logic [7:0] d, input int c);
    bit clr;
    clr      = !rs && (d >= 8'd1) && (d <= 8'd3);
    m_active = 1'b1;
    m_who    = who;
    m_g      = c;
    m_end    = c + 1 + S + P + H + (clr ? CLR : W);
    m_sel    = who;
    m_rs     = rs;
    exp_q.push_back({who, 31'(m_end)});
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_ack;
    bit in_txn;
    in_txn = m_active && (cyc > m_g) && (cyc <= m_end);
    check_eq("busy", busy, in_txn);
    check_eq("lcdE", lcdE, m_active && (cyc > m_g + S) && (cyc <= m_g + S + P));
    check_eq("setupAck", setupAck, m_active && (cyc == m_end) && !m_who);
    check_eq("charAck", charAck, m_active && (cyc == m_end) && m_who);
    check_eq("dOutSel", dOutSel, {1'b0, m_sel});
    check_eq("lcdRs", lcdRs, m_rs);
    check_eq("lcdRw", lcdRw, 1'b0);

    if (setupAck || charAck) begin
      check_eq("ack_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        exp_ack = exp_q.pop_front();
        check_eq("ack_order", {charAck, 31'(cyc)}, exp_ack);
      end
    end
    seen_sack = setupAck;
    seen_cack = charAck;
    if (setupAck) last_sack = cyc;
    if (charAck)  last_cack = cyc;
    if (lcdE && !prev_e) e_rise = cyc;
    if (lcdE) e_last = cyc;
    prev_e = lcdE;
    if (busy) any_busy = 1'b1;

    // Advance the model to the next edge.
    if (!rstN) begin
      m_active = 1'b0;
      m_sel    = 1'b0;
      m_rs     = 1'b0;
      exp_q.delete();
    end else if (!m_active || cyc > m_end) begin
      m_active = 1'b0;
      if (setupReq)                  model_grant(1'b0, setupRs, setup_data, cyc);
      else if (charReq && setupDone) model_grant(1'b1, charRs, char_data, cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (seen_sack) setupReq = 1'b0;
    if (seen_cack) charReq  = 1'b0;
  endtask

  task automatic wait_ack(input bit who, input int t0, input int bound, output int lat);
    int n = 0;
    while (((who ? last_cack : last_sack) < t0) && (n < bound)) begin
      step();
      n++;
    end
    check_eq(who ? "char_ack_seen" : "setup_ack_seen", (who ? last_cack : last_sack) >= t0, 1'b1);
    lat = (who ? last_cack : last_sack) - t0;
  endtask

  function automatic logic [7:0] rnd_data();
    if ($urandom_range(0, 2) == 0) return 8'($urandom_range(0, 3));
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t0, lat;
    rstN = 1'b0; setupReq = 1'b0; setupRs = 1'b0; charReq = 1'b0; charRs = 1'b0;
    setupDone = 1'b0; setup_data = 8'h00; char_data = 8'h00;
    repeat (3) step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_lcdE", lcdE, 1'b0);
    check_eq("rst_sel", dOutSel, 2'd0);
    rstN = 1'b1;
    repeat (2) step();

    // Normal setup write.
    setup_data = 8'h38; setupRs = 1'b0; setupReq = 1'b1; t0 = cyc;
    wait_ack(1'b0, t0, 60, lat);
    check_eq("s1_ack_lat", lat, 12);
    check_eq("s1_e_rise", e_rise - t0, 3);
    check_eq("s1_e_last", e_last - t0, 5);
    check_eq("s1_sel", dOutSel, 2'd0);
    check_eq("s1_rs", lcdRs, 1'b0);
    repeat (3) step();

    // Clear command gets the long settle.
    setup_data = 8'h01; setupRs = 1'b0; setupReq = 1'b1; t0 = cyc;
    wait_ack(1'b0, t0, 60, lat);
    check_eq("s2_ack_lat", lat, 18);
    repeat (3) step();

    // 0x01 as character data is not a clear.
    setupDone = 1'b1; char_data = 8'h01; charRs = 1'b1; charReq = 1'b1; t0 = cyc;
    wait_ack(1'b1, t0, 60, lat);
    check_eq("s3_ack_lat", lat, 12);
    check_eq("s3_sel", dOutSel, 2'd1);
    check_eq("s3_rs", lcdRs, 1'b1);
    repeat (3) step();

    // Character request blocked until setupDone.
    setupDone = 1'b0; char_data = 8'h41; charRs = 1'b1; charReq = 1'b1; t0 = cyc;
    any_busy = 1'b0;
    repeat (50) step();
    check_eq("s4_no_grant", any_busy, 1'b0);
    setupDone = 1'b1;
    wait_ack(1'b1, t0, 40, lat);
    check_eq("s4_ack_lat", lat, 62);
    repeat (3) step();

    // Simultaneous requests: setup first, char right after.
    setup_data = 8'h0C; setupRs = 1'b0; char_data = 8'h55; charRs = 1'b1;
    setupReq = 1'b1; charReq = 1'b1; t0 = cyc;
    wait_ack(1'b0, t0, 60, lat);
    check_eq("s5_setup_lat", lat, 12);
    wait_ack(1'b1, t0, 60, lat);
    check_eq("s5_char_lat", lat, 25);
    repeat (3) step();

    // Reset in the middle of PULSE aborts the write.
    char_data = 8'h48; charRs = 1'b1; charReq = 1'b1; t0 = cyc;
    repeat (4) step();
    check_eq("s6_e_before", lcdE, 1'b1);
    rstN = 1'b0; charReq = 1'b0;
    step();
    check_eq("s6_lcdE", lcdE, 1'b0);
    check_eq("s6_busy", busy, 1'b0);
    check_eq("s6_sel", dOutSel, 2'd0);
    check_eq("s6_rs", lcdRs, 1'b0);
    rstN = 1'b1;
    repeat (30) step();
    check_eq("s6_no_ack", last_cack >= t0, 1'b0);

    // Random traffic with occasional setupDone toggles and resets.
    setupDone = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      rstN = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 59) == 0) setupDone = !setupDone;
      if (!setupReq && !seen_sack && $urandom_range(0, 3) == 0) begin
        setupRs = 1'($urandom_range(0, 1)); setup_data = rnd_data(); setupReq = 1'b1;
      end
      if (!charReq && !seen_cack && $urandom_range(0, 3) == 0) begin
        charRs = 1'($urandom_range(0, 1)); char_data = rnd_data(); charReq = 1'b1;
      end
    end
    rstN = 1'b1; setupDone = 1'b1;
    repeat (80) step();
    check_eq("drain_q", exp_q.size(), 0);
    check_eq("drain_reqs", {setupReq, charReq}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
